chess_qspi_ctrl: RTL
====================

# chess_qspi_ctrl

Host-side command controller for the chess engine. It sits between the quad-SPI pins (sck, cs_n, sdi[3:0], sdo[3:0]) and the engine core. It synchronises the serial interface into the clk domain and decodes one command byte per transaction. It then sequences board loading into the engine's square memory, starts searches, and serialises status and the best-move result back to the host.

## Interface

Parameters:
- SYNC_STAGES, 2, synchroniser depth for sck/cs_n/sdi (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sck  in  1  host serial clock, asynchronous to clk
- cs_n  in  1  host chip select, active low
- sdi  in  4  host data nibble
- sdo  out  4  data nibble to host
- sdo_oe  out  1  sdo drive enable
- wr_en  out  1  one-cycle square write strobe to engine
- wr_addr  out  6  square index 0..63
- wr_data  out  4  piece code
- start  out  1  one-cycle search start pulse
- busy  in  1  engine searching
- result_valid  in  1  result_from/result_to hold a valid move
- result_from  in  6  best-move source square
- result_to  in  6  best-move destination square

## Operation

- Synchronisation: sck, cs_n and sdi each pass through SYNC_STAGES flops. The stages are aligned so sdi is sampled consistently with the sck edge. Rise/fall of sck is detected on the synchronised value by a registered compare. Edges while synced cs_n = 1 are ignored.
- Nibble order: host drives sdi, controller samples on each sck rising edge. Command byte = 2 nibbles, high first.
- FSM states:
  - IDLE → CMD_HI on synced cs_n falling.
  - CMD_HI → CMD_LO after the first sample.
  - CMD_LO → (decode after the second sample) LOAD / READ / SINK.
  - SINK: absorbs edges, no effect.
  - Synced cs_n = 1 forces IDLE from any state.
- Commands:
  - 0x01 LOAD: if busy = 0 at decode, go to LOAD. Each subsequent nibble produces a write with wr_addr = counter (starts 0) and wr_data = nibble, then the counter increments. After 64 writes, go to SINK. If busy = 1 at decode, set err and go to SINK.
  - 0x02 START: if busy = 0, pulse start once; else set err. Either way go to SINK.
  - 0x03 STATUS: load tx = {busy, result_valid, err, 0} (1 nibble). Go to READ. err is cleared when cs_n rises to end this transaction.
  - 0x04 RESULT: snapshot {result_from, result_to} at decode. tx nibbles, in order: from[5:2]; {from[1:0], to[5:4]}; to[3:0]. Go to READ.
  - Any other command: set err, go to SINK.
- READ:
  - sdo_oe = 1.
  - sdo shows the current tx nibble and advances on each detected sck falling edge.
  - Once the defined nibbles are exhausted, sdo = 0 with oe still 1.
  - sdi is ignored.
- LOAD abort: cs_n rising mid-LOAD keeps squares already written. The next LOAD restarts at address 0.
- err is a sticky flag. It is cleared only by a completed STATUS transaction or by reset.

## Timing

- Reset values: sdo = 0, sdo_oe = 0, wr_en = 0, wr_addr = 0, wr_data = 0, start = 0, err = 0, FSM = IDLE.
- Pin-edge to action latency = SYNC_STAGES + 1 clk. Applies to sck rise → wr_en/start, sck fall → sdo update, and cs_n edge → state change.
- wr_en and start are exactly 1 clk wide. wr_addr and wr_data are valid in the same cycle as wr_en and held until the next write.
- First tx nibble on sdo is valid within SYNC_STAGES + 2 clk of the sck rising edge that sampled the command low nibble.
- sdo_oe falls within SYNC_STAGES + 1 clk of cs_n rising.
- Host constraints:
  - sck high and low phases ≥ SYNC_STAGES + 2 clk each.
  - cs_n setup/hold to sck ≥ SYNC_STAGES + 2 clk.
- busy is sampled in the decode cycle only. A later busy change does not affect the ongoing transaction.
- Reset mid-transaction returns to IDLE immediately. The host must deassert cs_n before starting a new transaction.

## Test plan

- Reset, then idle: all outputs at their reset values. sck toggles with cs_n = 1 produce no wr_en, start or sdo_oe.
- LOAD with busy = 0: 0x01 then 64 nibbles with value i%16 → 64 wr_en pulses, wr_addr 0..63, wr_data = i%16. A 65th nibble produces no write.
- LOAD aborted after 10 nibbles, then a new LOAD of 3 nibbles → writes at addr 0..9, then addr 0..2.
- START with busy = 0 → one start pulse. START with busy = 1 → no pulse. A following STATUS reads 0b1x10 (err set); a second STATUS reads err = 0.
- RESULT with from = 12, to = 28, valid = 1 → sdo sequence 0x3, 0x1, 0xC, then 0x0. STATUS reads 0b0100 when busy = 0.
- Unknown command 0x7F → no writes or start, err = 1 on the next STATUS. Reset asserted mid-READ → sdo = 0 and sdo_oe = 0 immediately.

Source files
------------

// File: rtl/chess_qspi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chess_qspi_ctrl
// Description : Quad-SPI host command controller for the chess engine.
//               Synchronises sck/cs_n/sdi into clk, decodes one command byte
//               per transaction, streams board squares into the engine,
//               pulses search start and serialises status / best move.
// Revision    : 1.0 - initial release
// ============================================================================
module chess_qspi_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       cs_n,
    input  logic [3:0] sdi,
    output logic [3:0] sdo,
    output logic       sdo_oe,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [3:0] wr_data,
    output logic       start,
    input  logic       busy,
    input  logic       result_valid,
    input  logic [5:0] result_from,
    input  logic [5:0] result_to
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CMD_HI = 3'd1;
    localparam logic [2:0] c_ST_CMD_LO = 3'd2;
    localparam logic [2:0] c_ST_LOAD   = 3'd3;
    localparam logic [2:0] c_ST_READ   = 3'd4;
    localparam logic [2:0] c_ST_SINK   = 3'd5;

    localparam logic [7:0] c_CMD_LOAD   = 8'h01;
    localparam logic [7:0] c_CMD_START  = 8'h02;
    localparam logic [7:0] c_CMD_STATUS = 8'h03;
    localparam logic [7:0] c_CMD_RESULT = 8'h04;

    // All three pin synchronisers share one depth so sdi stays aligned with sck
    logic [SYNC_STAGES-1:0]      r_sck_sync;
    logic [SYNC_STAGES-1:0]      r_cs_sync;
    logic [SYNC_STAGES-1:0][3:0] r_sdi_sync;
    logic                        r_sck_d;
    logic                        r_cs_d;

    logic       w_sck_s;
    logic       w_cs_s;
    logic [3:0] w_sdi_s;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_cs_fall;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_cmd_hi;
    logic [5:0] r_addr;
    logic       r_err;
    logic       r_status_pend;
    logic [7:0] r_tx;
    logic [1:0] r_tx_left;

    logic [7:0] w_cmd;
    logic       w_cap_hi;
    logic       w_wr_fire;
    logic       w_dec_load;
    logic       w_start_fire;
    logic       w_err_set;
    logic       w_dec_status;
    logic       w_dec_result;
    logic       w_tx_shift;

    // Pin synchronisers plus one delayed copy of synced sck/cs_n for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '1;
            r_sdi_sync <= '0;
            r_sck_d    <= 1'b0;
            r_cs_d     <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_sck_d    <= w_sck_s;
            r_cs_d     <= w_cs_s;
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
    // sck edges only count while the host has the chip selected
    assign w_sck_rise = w_sck_s & ~r_sck_d & ~w_cs_s;
    assign w_sck_fall = ~w_sck_s & r_sck_d & ~w_cs_s;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;
    assign w_cmd      = {r_cmd_hi, w_sdi_s};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle action strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_cap_hi     = 1'b0;
        w_wr_fire    = 1'b0;
        w_dec_load   = 1'b0;
        w_start_fire = 1'b0;
        w_err_set    = 1'b0;
        w_dec_status = 1'b0;
        w_dec_result = 1'b0;
        w_tx_shift   = 1'b0;
        if (w_cs_s) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_cs_fall) w_state_nxt = c_ST_CMD_HI;
                end
                c_ST_CMD_HI: begin
                    if (w_sck_rise) begin
                        w_cap_hi    = 1'b1;
                        w_state_nxt = c_ST_CMD_LO;
                    end
                end
                c_ST_CMD_LO: begin
                    if (w_sck_rise) begin
                        case (w_cmd)
                            c_CMD_LOAD: begin
                                if (!busy) begin
                                    w_dec_load  = 1'b1;
                                    w_state_nxt = c_ST_LOAD;
                                end else begin
                                    w_err_set   = 1'b1;
                                    w_state_nxt = c_ST_SINK;
                                end
                            end
                            c_CMD_START: begin
                                if (!busy) w_start_fire = 1'b1;
                                else       w_err_set    = 1'b1;
                                w_state_nxt = c_ST_SINK;
                            end
                            c_CMD_STATUS: begin
                                w_dec_status = 1'b1;
                                w_state_nxt  = c_ST_READ;
                            end
                            c_CMD_RESULT: begin
                                w_dec_result = 1'b1;
                                w_state_nxt  = c_ST_READ;
                            end
                            default: begin
                                w_err_set   = 1'b1;
                                w_state_nxt = c_ST_SINK;
                            end
                        endcase
                    end
                end
                c_ST_LOAD: begin
                    if (w_sck_rise) begin
                        w_wr_fire = 1'b1;
                        if (r_addr == 6'd63) w_state_nxt = c_ST_SINK;
                    end
                end
                c_ST_READ: begin
                    if (w_sck_fall) w_tx_shift = 1'b1;
                end
                c_ST_SINK: begin
                    w_state_nxt = c_ST_SINK;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: command capture, square writes, start pulse, error flag, tx shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_hi      <= 4'h0;
            r_addr        <= 6'd0;
            r_err         <= 1'b0;
            r_status_pend <= 1'b0;
            r_tx          <= 8'h00;
            r_tx_left     <= 2'd0;
            sdo           <= 4'h0;
            sdo_oe        <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= 6'd0;
            wr_data       <= 4'h0;
            start         <= 1'b0;
        end else begin
            wr_en  <= w_wr_fire;
            start  <= w_start_fire;
            sdo_oe <= (w_state_nxt == c_ST_READ);

            if (w_cap_hi) r_cmd_hi <= w_sdi_s;

            if (w_dec_load) begin
                r_addr <= 6'd0;
            end else if (w_wr_fire) begin
                wr_addr <= r_addr;
                wr_data <= w_sdi_s;
                r_addr  <= r_addr + 6'd1;
            end

            // err survives everything except the end of a STATUS read
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_cs_s && r_status_pend) begin
                r_err <= 1'b0;
            end

            if (w_dec_status) begin
                r_status_pend <= 1'b1;
            end else if (w_cs_s) begin
                r_status_pend <= 1'b0;
            end

            // First nibble goes straight to sdo; the rest wait in r_tx
            if (w_dec_status) begin
                sdo       <= {busy, result_valid, r_err, 1'b0};
                r_tx_left <= 2'd0;
            end else if (w_dec_result) begin
                sdo       <= result_from[5:2];
                r_tx      <= {result_from[1:0], result_to};
                r_tx_left <= 2'd2;
            end else if (w_tx_shift) begin
                if (r_tx_left != 2'd0) begin
                    sdo       <= r_tx[7:4];
                    r_tx      <= {r_tx[3:0], 4'h0};
                    r_tx_left <= r_tx_left - 2'd1;
                end else begin
                    sdo <= 4'h0;
                end
            end else if (w_state_nxt != c_ST_READ) begin
                sdo <= 4'h0;
            end
        end
    end

endmodule
`default_nettype wire
